// File: rtl/cu_pkg.sv
// Shared types for the control-unit slice: control word, FSM states, select
// encodings and the opcode decode table.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_EXEC_WAIT,
    ST_INTER,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       rst;
    logic       io_strb;
    logic       pc_ld;
    logic       pc_inc;
    logic [1:0] pc_mux_sel;
    logic [3:0] alu_sel;
    logic       alu_opy_sel;
    logic       rf_wr;
    logic [1:0] rf_wr_sel;
    logic       sp_ld;
    logic       sp_incr;
    logic       sp_decr;
    logic       scr_we;
    logic       scr_data_sel;
    logic [1:0] scr_addr_sel;
    logic       i_set;
    logic       i_clr;
    logic       flg_c_set;
    logic       flg_c_clr;
    logic       flg_c_ld;
    logic       flg_z_ld;
    logic       flg_ld_sel;
    logic       flg_shad_ld;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDC = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBC = 4'd3;
  localparam logic [3:0] ALU_CMP  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_EXOR = 4'd7;
  localparam logic [3:0] ALU_TEST = 4'd8;
  localparam logic [3:0] ALU_LSL  = 4'd9;
  localparam logic [3:0] ALU_MOV  = 4'd14;

  localparam logic [1:0] PC_SEL_IMM = 2'd0;
  localparam logic [1:0] PC_SEL_STK = 2'd1;
  localparam logic [1:0] PC_SEL_VEC = 2'd2;

  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_SCR = 2'd1;
  localparam logic [1:0] RF_SEL_SP  = 2'd2;
  localparam logic [1:0] RF_SEL_IN  = 2'd3;

  localparam logic [1:0] SCR_ADDR_REG  = 2'd0;
  localparam logic [1:0] SCR_ADDR_IMM  = 2'd1;
  localparam logic [1:0] SCR_ADDR_SP   = 2'd2;
  localparam logic [1:0] SCR_ADDR_SPM1 = 2'd3;

  localparam logic SCR_DATA_REG = 1'b0;
  localparam logic SCR_DATA_PC  = 1'b1;
  localparam logic FLG_SEL_ALU  = 1'b0;
  localparam logic FLG_SEL_SHAD = 1'b1;

  // Index order shared by the reg/reg and reg/imm arithmetic-logic groups.
  function automatic logic [3:0] alu_code(input logic [2:0] idx);
    case (idx)
      3'd0:    alu_code = ALU_AND;
      3'd1:    alu_code = ALU_OR;
      3'd2:    alu_code = ALU_EXOR;
      3'd3:    alu_code = ALU_TEST;
      3'd4:    alu_code = ALU_ADD;
      3'd5:    alu_code = ALU_ADDC;
      3'd6:    alu_code = ALU_SUB;
      default: alu_code = ALU_SUBC;
    endcase
  endfunction

  function automatic logic is_scr_read(input logic [6:0] op);
    casez (op)
      7'b0001010, 7'b11100??, 7'b0100110,
      7'b0110010, 7'b0110110, 7'b0110111: is_scr_read = 1'b1;
      default:                            is_scr_read = 1'b0;
    endcase
  endfunction

  function automatic ctrl_t isa_table(input logic [6:0] op, input logic c, input logic z);
    ctrl_t w;
    w = '0;
    casez (op)
      7'b0000???, 7'b10?????: begin
        w.alu_sel     = alu_code(op[6] ? op[4:2] : op[2:0]);
        w.alu_opy_sel = op[6];
        w.rf_wr       = (w.alu_sel != ALU_TEST);
        w.flg_c_ld    = 1'b1;
        w.flg_z_ld    = 1'b1;
      end
      7'b0001000, 7'b11000??: begin
        w.alu_sel     = ALU_CMP;
        w.alu_opy_sel = op[6];
        w.flg_c_ld    = 1'b1;
        w.flg_z_ld    = 1'b1;
      end
      7'b0001001, 7'b11011??: begin
        w.alu_sel     = ALU_MOV;
        w.alu_opy_sel = op[6];
        w.rf_wr       = 1'b1;
      end
      7'b0001010, 7'b11100??: begin
        w.rf_wr        = 1'b1;
        w.rf_wr_sel    = RF_SEL_SCR;
        w.scr_addr_sel = op[6] ? SCR_ADDR_IMM : SCR_ADDR_REG;
      end
      7'b0001011, 7'b11101??: begin
        w.scr_we       = 1'b1;
        w.scr_addr_sel = op[6] ? SCR_ADDR_IMM : SCR_ADDR_REG;
      end
      7'b11001??: begin
        w.rf_wr     = 1'b1;
        w.rf_wr_sel = RF_SEL_IN;
      end
      7'b11010??: w.io_strb = 1'b1;
      7'b0010000: w.pc_ld = 1'b1;
      7'b0010001: begin
        w.pc_ld        = 1'b1;
        w.scr_we       = 1'b1;
        w.scr_data_sel = SCR_DATA_PC;
        w.scr_addr_sel = SCR_ADDR_SPM1;
        w.sp_decr      = 1'b1;
      end
      7'b0010010: w.pc_ld = z;
      7'b0010011: w.pc_ld = ~z;
      7'b0010100: w.pc_ld = c;
      7'b0010101: w.pc_ld = ~c;
      7'b0100000, 7'b0100001, 7'b0100010, 7'b0100011, 7'b0100100: begin
        w.alu_sel  = ALU_LSL + {1'b0, op[2:0]};
        w.rf_wr    = 1'b1;
        w.flg_c_ld = 1'b1;
        w.flg_z_ld = 1'b1;
      end
      7'b0100101: begin
        w.scr_we       = 1'b1;
        w.scr_data_sel = SCR_DATA_REG;
        w.scr_addr_sel = SCR_ADDR_SPM1;
        w.sp_decr      = 1'b1;
      end
      7'b0100110: begin
        w.rf_wr        = 1'b1;
        w.rf_wr_sel    = RF_SEL_SCR;
        w.scr_addr_sel = SCR_ADDR_SP;
        w.sp_incr      = 1'b1;
      end
      7'b0101000: w.sp_ld = 1'b1;
      7'b0101001: begin
        w.rf_wr     = 1'b1;
        w.rf_wr_sel = RF_SEL_SP;
      end
      7'b0110000: w.flg_c_clr = 1'b1;
      7'b0110001: w.flg_c_set = 1'b1;
      7'b0110100: w.i_set = 1'b1;
      7'b0110101: w.i_clr = 1'b1;
      7'b0110010, 7'b0110110, 7'b0110111: begin
        w.pc_ld        = 1'b1;
        w.pc_mux_sel   = PC_SEL_STK;
        w.scr_addr_sel = SCR_ADDR_SP;
        w.sp_incr      = 1'b1;
        // RETID/RETIE also restore the flags saved on interrupt entry.
        if (op[2]) begin
          w.flg_ld_sel = FLG_SEL_SHAD;
          w.flg_c_ld   = 1'b1;
          w.flg_z_ld   = 1'b1;
          w.i_set      = op[0];
          w.i_clr      = ~op[0];
        end
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Interrupt front end: rising-edge capture into pending bits, masking,
// lowest-index-wins priority and the registered vector of the line in service.
module irq_arbiter #(
  parameter int NUM_INT    = 4,
  parameter int PC_W       = 10,
  parameter int VEC_BASE   = 10'h3F8,
  parameter int VEC_STRIDE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_INT-1:0] i_irq,
  input  logic [NUM_INT-1:0] i_mask,
  input  logic               i_en,
  input  logic               i_load,
  input  logic               i_ack_en,
  output logic               o_take_int,
  output logic [NUM_INT-1:0] o_int_ack,
  output logic [PC_W-1:0]    o_int_vec
);

  localparam logic [PC_W-1:0] BASE_W   = PC_W'(VEC_BASE);
  localparam logic [PC_W-1:0] STRIDE_W = PC_W'(VEC_STRIDE);

  logic [NUM_INT-1:0] r_irq_d;
  logic [NUM_INT-1:0] r_pending;
  logic [2:0]         r_win;
  logic [PC_W-1:0]    r_vec;
  logic [NUM_INT-1:0] w_rise;
  logic [NUM_INT-1:0] w_req;
  logic [2:0]         w_win;
  logic [PC_W-1:0]    w_vec;

  assign w_rise     = i_irq & ~r_irq_d;
  assign w_req      = r_pending & i_mask;
  assign o_take_int = i_en & (|w_req);
  assign w_vec      = BASE_W + PC_W'(w_win) * STRIDE_W;
  assign o_int_vec  = r_vec;

  always_comb begin
    w_win = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (w_req[i]) w_win = 3'(i);
    end
  end

  always_comb begin
    o_int_ack = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      o_int_ack[i] = i_ack_en && (r_win == 3'(i));
    end
  end

  // Winner and vector are frozen on entry so a late higher-priority edge
  // cannot change which line is acknowledged mid-entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_irq_d   <= '0;
      r_pending <= '0;
      r_win     <= '0;
      r_vec     <= '0;
    end else begin
      r_irq_d   <= i_irq;
      r_pending <= (r_pending & ~o_int_ack) | w_rise;
      if (i_load) begin
        r_win <= w_win;
        r_vec <= w_vec;
      end
    end
  end

endmodule

// File: rtl/cu_sequencer.sv
// MCU control unit: FETCH/EXEC sequencing with scratch-read stall, vectored
// interrupt entry and a HALT/wake state; emits one packed control word.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int NUM_INT    = 4,
  parameter int PC_W       = 10,
  parameter int VEC_BASE   = 10'h3F8,
  parameter int VEC_STRIDE = 1,
  parameter int SCR_RD_LAT = 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [4:0]         OPCODE_HI_5,
  input  logic [1:0]         OPCODE_LO_2,
  input  logic               C,
  input  logic               Z,
  input  logic               I_EN,
  input  logic [NUM_INT-1:0] IRQ,
  input  logic [NUM_INT-1:0] IRQ_MASK,
  input  logic               HALT,
  output ctrl_t              CTRL,
  output logic [PC_W-1:0]    INT_VEC,
  output logic [NUM_INT-1:0] INT_ACK,
  output logic               HALTED,
  output state_t             o_dbg_state
);

  localparam logic [1:0] LAT      = 2'(SCR_RD_LAT);
  localparam bit         HAS_WAIT = (SCR_RD_LAT != 0);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_wait_cnt;
  logic [1:0] w_wait_nxt;
  logic [6:0] r_op;
  logic [6:0] w_op;
  ctrl_t      w_dec;
  logic       w_final;
  logic       w_take_int;

  assign w_op        = (r_state == ST_EXEC_WAIT) ? r_op : {OPCODE_HI_5, OPCODE_LO_2};
  assign w_dec       = isa_table(w_op, C, Z);
  assign o_dbg_state = r_state;

  irq_arbiter #(
    .NUM_INT   (NUM_INT),
    .PC_W      (PC_W),
    .VEC_BASE  (VEC_BASE),
    .VEC_STRIDE(VEC_STRIDE)
  ) u_irq_arbiter (
    .i_clk     (CLK),
    .i_rst_n   (RESET_N),
    .i_irq     (IRQ),
    .i_mask    (IRQ_MASK),
    .i_en      (I_EN),
    .i_load    (w_next_state == ST_INTER),
    .i_ack_en  (r_state == ST_INTER),
    .o_take_int(w_take_int),
    .o_int_ack (INT_ACK),
    .o_int_vec (INT_VEC)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state    <= ST_INIT;
      r_wait_cnt <= '0;
      r_op       <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_nxt;
      if (r_state == ST_EXEC) r_op <= w_op;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_final      = 1'b0;
    CTRL         = '0;
    HALTED       = 1'b0;
    case (r_state)
      ST_INIT: begin
        CTRL.rst     = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        CTRL.pc_inc  = 1'b1;
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        // Scratch reads present only the address until the data is valid.
        if (HAS_WAIT && is_scr_read(w_op)) begin
          CTRL.scr_addr_sel = w_dec.scr_addr_sel;
          w_wait_nxt        = LAT;
          w_next_state      = ST_EXEC_WAIT;
        end else begin
          CTRL    = w_dec;
          w_final = 1'b1;
        end
      end
      ST_EXEC_WAIT: begin
        w_wait_nxt = r_wait_cnt - 2'd1;
        if (r_wait_cnt == 2'd1) begin
          CTRL    = w_dec;
          w_final = 1'b1;
        end else begin
          CTRL.scr_addr_sel = w_dec.scr_addr_sel;
        end
      end
      ST_INTER: begin
        CTRL.pc_mux_sel   = PC_SEL_VEC;
        CTRL.pc_ld        = 1'b1;
        CTRL.scr_data_sel = SCR_DATA_PC;
        CTRL.scr_we       = 1'b1;
        CTRL.scr_addr_sel = SCR_ADDR_SPM1;
        CTRL.sp_decr      = 1'b1;
        CTRL.flg_shad_ld  = 1'b1;
        CTRL.i_clr        = 1'b1;
        w_next_state      = HALT ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        HALTED = 1'b1;
        if (w_take_int)  w_next_state = ST_INTER;
        else if (!HALT)  w_next_state = ST_FETCH;
      end
      default: w_next_state = ST_INIT;
    endcase
    if (w_final) begin
      if (w_take_int)  w_next_state = ST_INTER;
      else if (HALT)   w_next_state = ST_HALT;
      else             w_next_state = ST_FETCH;
    end
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: reset, ALU decode, stalled POP, branch,
// interrupt priority/masking, HALT/wake and reset abort.
module tb_cu_sequencer;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] op_hi;
  logic [1:0] op_lo;
  logic       c_f, z_f, i_en, halt;
  logic [3:0] irq, irq_mask;
  ctrl_t      ctrl_o;
  logic [9:0] int_vec;
  logic [3:0] int_ack;
  logic       halted;
  state_t     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  ctrl_t e_init, e_fetch, e_add, e_inter, e_pop_addr, e_pop, e_br;

  always #5 clk = ~clk;

  cu_sequencer #(
    .NUM_INT(4), .PC_W(10), .VEC_BASE(10'h3F8), .VEC_STRIDE(1), .SCR_RD_LAT(2)
  ) dut (
    .CLK(clk), .RESET_N(reset_n), .OPCODE_HI_5(op_hi), .OPCODE_LO_2(op_lo),
    .C(c_f), .Z(z_f), .I_EN(i_en), .IRQ(irq), .IRQ_MASK(irq_mask), .HALT(halt),
    .CTRL(ctrl_o), .INT_VEC(int_vec), .INT_ACK(int_ack), .HALTED(halted),
    .o_dbg_state(dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op);
    {op_hi, op_lo} = op;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    tick;
    n_checks++;
    if (ctrl_o !== e_init) begin n_errors++; $display("FAIL reset_hold ctrl got %h exp %h", ctrl_o, e_init); end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== ST_INIT || ctrl_o !== e_init) begin n_errors++; $display("FAIL reset_init state %0d ctrl got %h exp %h", dbg_state, ctrl_o, e_init); end
    n_checks++;
    if (int_ack !== 4'b0000 || halted !== 1'b0) begin n_errors++; $display("FAIL reset_outs ack %b halted %b exp 0000 0", int_ack, halted); end
    tick;
    n_checks++;
    if (ctrl_o !== e_fetch) begin n_errors++; $display("FAIL reset_fetch ctrl got %h exp %h", ctrl_o, e_fetch); end
  endtask

  task automatic test_add;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_checks++;
      if (ctrl_o !== e_add || dbg_state !== ST_EXEC) begin n_errors++; $display("FAIL add_exec%0d ctrl got %h exp %h", k, ctrl_o, e_add); end
      tick;
      n_checks++;
      if (ctrl_o !== e_fetch) begin n_errors++; $display("FAIL add_fetch%0d ctrl got %h exp %h", k, ctrl_o, e_fetch); end
    end
  endtask

  task automatic test_branch;
    set_op(7'b0010010);
    z_f = 1'b1;
    tick;
    n_checks++;
    if (ctrl_o !== e_br) begin n_errors++; $display("FAIL breq_taken ctrl got %h exp %h", ctrl_o, e_br); end
    tick;
    z_f = 1'b0;
    tick;
    n_checks++;
    if (ctrl_o !== ctrl_t'('0)) begin n_errors++; $display("FAIL breq_not_taken ctrl got %h exp 0", ctrl_o); end
    tick;
    set_op(7'b0000100);
  endtask

  task automatic test_pop;
    int sp_cnt;
    sp_cnt = 0;
    set_op(7'b0100110);
    tick;
    sp_cnt += int'(ctrl_o.sp_incr);
    n_checks++;
    if (ctrl_o !== e_pop_addr || dbg_state !== ST_EXEC) begin n_errors++; $display("FAIL pop_exec ctrl got %h exp %h", ctrl_o, e_pop_addr); end
    tick;
    sp_cnt += int'(ctrl_o.sp_incr);
    n_checks++;
    if (ctrl_o !== e_pop_addr || dbg_state !== ST_EXEC_WAIT) begin n_errors++; $display("FAIL pop_wait ctrl got %h exp %h", ctrl_o, e_pop_addr); end
    tick;
    sp_cnt += int'(ctrl_o.sp_incr);
    n_checks++;
    if (ctrl_o !== e_pop) begin n_errors++; $display("FAIL pop_final ctrl got %h exp %h", ctrl_o, e_pop); end
    tick;
    sp_cnt += int'(ctrl_o.sp_incr);
    n_checks++;
    if (ctrl_o !== e_fetch) begin n_errors++; $display("FAIL pop_fetch ctrl got %h exp %h", ctrl_o, e_fetch); end
    n_checks++;
    if (sp_cnt != 1) begin n_errors++; $display("FAIL pop_sp_once count %0d exp 1", sp_cnt); end
    set_op(7'b0000100);
  endtask

  task automatic test_irq_priority;
    irq = 4'b0110;
    irq_mask = 4'b1111;
    i_en = 1'b1;
    tick;
    n_checks++;
    if (ctrl_o !== e_add) begin n_errors++; $display("FAIL irq_add ctrl got %h exp %h", ctrl_o, e_add); end
    tick;
    n_checks++;
    if (ctrl_o !== e_inter || int_ack !== 4'b0010 || int_vec !== 10'h3F9) begin
      n_errors++; $display("FAIL irq_first ctrl %h ack %b vec %h exp %h 0010 3f9", ctrl_o, int_ack, int_vec, e_inter);
    end
    tick;
    tick;
    tick;
    n_checks++;
    if (int_ack !== 4'b0100 || int_vec !== 10'h3FA || dbg_state !== ST_INTER) begin
      n_errors++; $display("FAIL irq_second ack %b vec %h exp 0100 3fa", int_ack, int_vec);
    end
    irq = 4'b0000;
    tick;
    n_checks++;
    if (ctrl_o !== e_fetch || int_ack !== 4'b0000 || int_vec !== 10'h3FA) begin
      n_errors++; $display("FAIL irq_after ctrl %h ack %b vec %h exp %h 0000 3fa", ctrl_o, int_ack, int_vec, e_fetch);
    end
  endtask

  task automatic test_mask;
    irq_mask = 4'b1110;
    irq = 4'b0001;
    tick;
    irq = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_checks++;
      if (ctrl_o !== e_fetch || int_ack !== 4'b0000) begin n_errors++; $display("FAIL mask_hold%0d ctrl %h ack %b exp %h 0000", k, ctrl_o, int_ack, e_fetch); end
      if (k == 0) tick;
    end
    irq_mask = 4'b1111;
    tick;
    tick;
    n_checks++;
    if (int_ack !== 4'b0001 || int_vec !== 10'h3F8) begin n_errors++; $display("FAIL mask_unmask ack %b vec %h exp 0001 3f8", int_ack, int_vec); end
    irq = 4'b0001;
    tick;
    tick;
    tick;
    n_checks++;
    if (int_ack !== 4'b0001 || dbg_state !== ST_INTER) begin n_errors++; $display("FAIL mask_reedge ack %b state %0d exp 0001 inter", int_ack, dbg_state); end
    irq = 4'b0000;
    tick;
    tick;
    tick;
    n_checks++;
    if (ctrl_o !== e_fetch) begin n_errors++; $display("FAIL mask_drained ctrl got %h exp %h", ctrl_o, e_fetch); end
  endtask

  task automatic test_halt;
    tick;
    halt = 1'b1;
    tick;
    n_checks++;
    if (halted !== 1'b1 || ctrl_o !== ctrl_t'('0) || dbg_state !== ST_HALT) begin
      n_errors++; $display("FAIL halt_enter halted %b ctrl %h exp 1 0", halted, ctrl_o);
    end
    tick;
    irq = 4'b1000;
    tick;
    n_checks++;
    if (halted !== 1'b1 || int_ack !== 4'b0000) begin n_errors++; $display("FAIL halt_stay halted %b ack %b exp 1 0000", halted, int_ack); end
    tick;
    n_checks++;
    if (int_ack !== 4'b1000 || int_vec !== 10'h3FB || halted !== 1'b0 || ctrl_o !== e_inter) begin
      n_errors++; $display("FAIL halt_wake ack %b vec %h halted %b exp 1000 3fb 0", int_ack, int_vec, halted);
    end
    tick;
    n_checks++;
    if (halted !== 1'b1 || dbg_state !== ST_HALT) begin n_errors++; $display("FAIL halt_return halted %b exp 1", halted); end
    halt = 1'b0;
    irq = 4'b0000;
    tick;
    n_checks++;
    if (ctrl_o !== e_fetch || halted !== 1'b0) begin n_errors++; $display("FAIL halt_release ctrl %h halted %b exp %h 0", ctrl_o, halted, e_fetch); end
  endtask

  task automatic test_reset_abort;
    int sp_cnt;
    sp_cnt = 0;
    set_op(7'b0100110);
    tick;
    tick;
    reset_n = 1'b0;
    tick;
    sp_cnt += int'(ctrl_o.sp_incr);
    n_checks++;
    if (ctrl_o !== e_init || dbg_state !== ST_INIT) begin n_errors++; $display("FAIL abort_init ctrl got %h exp %h", ctrl_o, e_init); end
    reset_n = 1'b1;
    tick;
    sp_cnt += int'(ctrl_o.sp_incr);
    n_checks++;
    if (ctrl_o !== e_fetch || sp_cnt != 0) begin n_errors++; $display("FAIL abort_fetch ctrl %h sp_incr %0d exp %h 0", ctrl_o, sp_cnt, e_fetch); end
    set_op(7'b0000100);
  endtask

  initial begin
    e_init = '0;  e_init.rst = 1'b1;
    e_fetch = '0; e_fetch.pc_inc = 1'b1;
    e_add = '0;   e_add.rf_wr = 1'b1; e_add.flg_c_ld = 1'b1; e_add.flg_z_ld = 1'b1; e_add.alu_sel = 4'd0;
    e_br = '0;    e_br.pc_ld = 1'b1;
    e_pop_addr = '0; e_pop_addr.scr_addr_sel = 2'd2;
    e_pop = '0;   e_pop.rf_wr = 1'b1; e_pop.rf_wr_sel = 2'd1; e_pop.scr_addr_sel = 2'd2; e_pop.sp_incr = 1'b1;
    e_inter = '0;
    e_inter.pc_mux_sel = 2'd2; e_inter.pc_ld = 1'b1; e_inter.scr_data_sel = 1'b1;
    e_inter.scr_we = 1'b1; e_inter.scr_addr_sel = 2'd3; e_inter.sp_decr = 1'b1;
    e_inter.flg_shad_ld = 1'b1; e_inter.i_clr = 1'b1;

    reset_n = 1'b0;
    set_op(7'b0000100);
    c_f = 1'b0; z_f = 1'b0; i_en = 1'b0; halt = 1'b0;
    irq = 4'b0000; irq_mask = 4'b1111;

    test_reset;
    test_add;
    test_branch;
    test_pop;
    test_irq_priority;
    test_mask;
    test_halt;
    test_reset_abort;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
